// File: rtl/metric_buffer_if.sv
// Handshake and data bundle between a trellis engine (master) and the metric buffer (slave).
interface metric_buffer_if #(
    parameter int DATA_W     = 16,
    parameter int NUM_STATES = 8,
    parameter int DEPTH      = 64
);
    localparam int AW = $clog2(DEPTH + 1);
    localparam int VW = NUM_STATES * DATA_W;

    logic          start;
    logic [AW-1:0] frame_len;
    logic          rd_reverse;
    logic          wr_valid;
    logic [VW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [VW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] rd_step;
    logic          write_done;
    logic          read_done;
    logic          err;
    logic          busy;

    modport master (
        output start, frame_len, rd_reverse, wr_valid, wr_data, rd_req,
        input  wr_ready, rd_data, rd_valid, rd_step, write_done, read_done, err, busy
    );

    modport slave (
        input  start, frame_len, rd_reverse, wr_valid, wr_data, rd_req,
        output wr_ready, rd_data, rd_valid, rd_step, write_done, read_done, err, busy
    );
endinterface

// File: rtl/metric_buffer.sv
// Frame buffer for Viterbi state-metric vectors: fill one frame, then replay it
// forward or reversed with one-cycle read latency.
module metric_buffer #(
    parameter int DATA_W     = 16,
    parameter int NUM_STATES = 8,
    parameter int DEPTH      = 64
) (
    input  logic          clk,
    input  logic          rst,
    metric_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int VW = NUM_STATES * DATA_W;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t        state_q;
    logic [AW-1:0] len_q;
    logic          rev_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          rd_valid_q;
    logic [VW-1:0] rd_data_q;
    logic [AW-1:0] rd_step_q;
    logic          write_done_q;
    logic          read_done_q;
    logic          err_q;

    logic [VW-1:0] mem [DEPTH];

    logic wr_en;
    logic rd_en;
    logic wr_last;
    logic rd_last;
    logic len_ok;

    assign wr_en   = (state_q == WRITE) && bus.wr_valid;
    assign rd_en   = (state_q == READ) && bus.rd_req;
    assign wr_last = (wr_ptr_q == len_q - ONE_A);
    assign rd_last = rev_q ? (rd_ptr_q == '0) : (rd_ptr_q == len_q - ONE_A);
    assign len_ok  = (bus.frame_len != '0) && (bus.frame_len <= DEPTH_A);

    // Storage is deliberately outside the reset domain so frames survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[IW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            rev_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_step_q    <= '0;
            write_done_q <= 1'b0;
            read_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_valid_q   <= 1'b0;
            write_done_q <= 1'b0;
            read_done_q  <= 1'b0;
            err_q        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            len_q    <= bus.frame_len;
                            rev_q    <= bus.rd_reverse;
                            wr_ptr_q <= '0;
                            state_q  <= WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + ONE_A;
                        if (wr_last) begin
                            write_done_q <= 1'b1;
                            rd_ptr_q     <= rev_q ? (len_q - ONE_A) : '0;
                            state_q      <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_en) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= mem[rd_ptr_q[IW-1:0]];
                        rd_step_q  <= rd_ptr_q;
                        if (rd_last) begin
                            // Final vector is still in flight while IDLE may accept a new start.
                            read_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            rd_ptr_q <= rev_q ? (rd_ptr_q - ONE_A) : (rd_ptr_q + ONE_A);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready   = (state_q == WRITE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_step    = rd_step_q;
    assign bus.write_done = write_done_q;
    assign bus.read_done  = read_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_metric_buffer.sv
// Scoreboard bench for metric_buffer: stimulus queues expected read vectors, a monitor pops them.
module tb_metric_buffer;
    localparam int DATA_W     = 16;
    localparam int NUM_STATES = 8;
    localparam int DEPTH      = 64;
    localparam int AW         = $clog2(DEPTH + 1);
    localparam int VW         = NUM_STATES * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    metric_buffer_if #(.DATA_W(DATA_W), .NUM_STATES(NUM_STATES), .DEPTH(DEPTH)) mb_if ();

    metric_buffer #(.DATA_W(DATA_W), .NUM_STATES(NUM_STATES), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mb_if)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] step;
        logic [VW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [VW-1:0] vec(input int s);
        logic [VW-1:0] v;
        for (int k = 0; k < NUM_STATES; k++) v[k*DATA_W +: DATA_W] = DATA_W'(16 * s + k);
        return v;
    endfunction

    // Monitor: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mb_if.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", VW'(1), VW'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_cycle", VW'(cyc), VW'(mon_e.cyc));
                    check("rd_step", VW'(mb_if.rd_step), VW'(mon_e.step));
                    check("rd_data", mb_if.rd_data, mon_e.data);
                    check("read_done", VW'(mb_if.read_done), VW'(mon_e.last));
                    $display("read step %0d data %0h done %0b", mb_if.rd_step, mb_if.rd_data, mb_if.read_done);
                end
            end else if (mb_if.read_done) begin
                check("read_done_without_valid", VW'(1), VW'(0));
            end
        end
    end

    task automatic start_frame(input int len, input logic rev);
        mb_if.start      = 1'b1;
        mb_if.frame_len  = AW'(len);
        mb_if.rd_reverse = rev;
        @(negedge clk);
        mb_if.start = 1'b0;
    endtask

    task automatic write_vec(input logic [VW-1:0] d);
        mb_if.wr_valid = 1'b1;
        mb_if.wr_data  = d;
        @(negedge clk);
        mb_if.wr_valid = 1'b0;
    endtask

    task automatic read_vec(input int step, input logic [VW-1:0] d, input logic last);
        exp_t e;
        e.cyc  = cyc + 1;
        e.step = AW'(step);
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
        mb_if.rd_req = 1'b1;
        @(negedge clk);
        mb_if.rd_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, VW'(mb_if.busy), VW'(0));
        check({tag, "_wr_ready"}, VW'(mb_if.wr_ready), VW'(0));
        check({tag, "_rd_valid"}, VW'(mb_if.rd_valid), VW'(0));
        check({tag, "_rd_data"}, mb_if.rd_data, VW'(0));
        check({tag, "_rd_step"}, VW'(mb_if.rd_step), VW'(0));
        check({tag, "_pulses"}, VW'({mb_if.write_done, mb_if.read_done, mb_if.err}), VW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] d;
        logic [VW-1:0] va, vx, vb, vc;
        int            bad_lens[2];
        mb_if.start = 1'b0;
        mb_if.frame_len = '0;
        mb_if.rd_reverse = 1'b0;
        mb_if.wr_valid = 1'b0;
        mb_if.wr_data = '0;
        mb_if.rd_req = 1'b0;

        #1 rst = 1'b1;
        #1 check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Forward frame of 4
        start_frame(4, 1'b0);
        check("fwd_busy", VW'(mb_if.busy), VW'(1));
        check("fwd_wr_ready", VW'(mb_if.wr_ready), VW'(1));
        for (int s = 0; s < 4; s++) write_vec(vec(s));
        check("fwd_write_done", VW'(mb_if.write_done), VW'(1));
        check("fwd_wr_ready_after", VW'(mb_if.wr_ready), VW'(0));
        for (int s = 0; s < 4; s++) read_vec(s, vec(s), s == 3);
        check("fwd_busy_end", VW'(mb_if.busy), VW'(0));
        @(negedge clk);

        // Reverse full-depth frame with -1 in the top state of the last step
        start_frame(DEPTH, 1'b1);
        for (int s = 0; s < DEPTH; s++) begin
            d = vec(s);
            if (s == DEPTH - 1) d[VW-1 -: DATA_W] = 16'hFFFF;
            write_vec(d);
        end
        check("rev_write_done", VW'(mb_if.write_done), VW'(1));
        for (int s = DEPTH - 1; s >= 0; s--) begin
            d = vec(s);
            if (s == DEPTH - 1) d[VW-1 -: DATA_W] = 16'hFFFF;
            read_vec(s, d, s == 0);
        end
        @(negedge clk);

        // Illegal lengths
        bad_lens[0] = 0;
        bad_lens[1] = DEPTH + 1;
        for (int i = 0; i < 2; i++) begin
            start_frame(bad_lens[i], 1'b0);
            check("illegal_err", VW'(mb_if.err), VW'(1));
            check("illegal_busy", VW'(mb_if.busy), VW'(0));
            check("illegal_wr_ready", VW'(mb_if.wr_ready), VW'(0));
            @(negedge clk);
            check("illegal_err_clear", VW'(mb_if.err), VW'(0));
            check("illegal_busy_after", VW'(mb_if.busy), VW'(0));
        end

        // Write gaps and gapped reads
        va = vec(20); vx = vec(30); vb = vec(21); vc = vec(22);
        start_frame(3, 1'b0);
        write_vec(va);
        mb_if.wr_data = vx;
        @(negedge clk);
        write_vec(vb);
        write_vec(vc);
        check("gap_write_done", VW'(mb_if.write_done), VW'(1));
        read_vec(0, va, 1'b0);
        @(negedge clk);
        @(negedge clk);
        read_vec(1, vb, 1'b0);
        @(negedge clk);
        read_vec(2, vc, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of a write phase
        start_frame(4, 1'b0);
        write_vec(vec(40));
        write_vec(vec(41));
        #2 rst = 1'b1;
        #1 check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_frame(2, 1'b0);
        write_vec(vec(50));
        write_vec(vec(51));
        read_vec(0, vec(50), 1'b0);
        read_vec(1, vec(51), 1'b1);
        @(negedge clk);

        // rd_req during WRITE and start during READ must be ignored
        start_frame(2, 1'b0);
        mb_if.rd_req = 1'b1;
        write_vec(vec(60));
        mb_if.rd_req = 1'b0;
        write_vec(vec(61));
        check("ign_write_done", VW'(mb_if.write_done), VW'(1));
        mb_if.start = 1'b1;
        mb_if.frame_len = AW'(3);
        read_vec(0, vec(60), 1'b0);
        mb_if.start = 1'b0;
        check("ign_wr_ready", VW'(mb_if.wr_ready), VW'(0));
        read_vec(1, vec(61), 1'b1);
        check("ign_busy_end", VW'(mb_if.busy), VW'(0));

        repeat (3) @(negedge clk);
        check("queue_drained", VW'(exp_q.size()), VW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/metric_buffer.md
METRIC_BUFFER -- requirements
Module: metric_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of one signed state metric.
REQ-002 SHALL have parameter NUM_STATES, default 8, meaning metrics stored per trellis step (one vector).
REQ-003 SHALL have parameter DEPTH, default 64, meaning maximum trellis steps per frame; AW = ceil(log2(DEPTH+1)).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, meaning frame start pulse, sampled only in IDLE.
REQ-007 SHALL have port frame_len, input, AW, meaning steps in frame, sampled with start.
REQ-008 SHALL have port rd_reverse, input, 1, meaning read order select (1 = last step first), sampled with start.
REQ-009 SHALL have port wr_valid, input, 1, meaning wr_data holds a metric vector.
REQ-010 SHALL have port wr_data, input, NUM_STATES*DATA_W, meaning packed signed metrics, state 0 in LSBs.
REQ-011 SHALL have port wr_ready, output, 1, meaning buffer accepts a vector this cycle.
REQ-012 SHALL have port rd_req, input, 1, meaning request next vector in read order.
REQ-013 SHALL have port rd_data, output, NUM_STATES*DATA_W, meaning read vector, same packing as wr_data.
REQ-014 SHALL have port rd_valid, output, 1, meaning rd_data and rd_step valid this cycle.
REQ-015 SHALL have port rd_step, output, AW, meaning trellis step index of rd_data.
REQ-016 SHALL have ports write_done, read_done, err, output, 1 each, meaning single-cycle event pulses.
REQ-017 SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, WRITE, READ; busy = (state != IDLE).
REQ-019 IDLE: start with 1 <= frame_len <= DEPTH SHALL latch frame_len, rd_reverse, clear wr_ptr, enter WRITE next cycle.
REQ-020 IDLE: start with frame_len = 0 or > DEPTH SHALL pulse err one cycle after and remain in IDLE.
REQ-021 start outside IDLE SHALL be ignored, no err.
REQ-022 wr_ready SHALL be 1 exactly while in WRITE; write occurs when wr_valid && wr_ready; vector stored at address wr_ptr, wr_ptr increments.
REQ-023 On the write with wr_ptr = frame_len-1: write_done pulses next cycle, state enters READ, rd_ptr = frame_len-1 if reverse else 0.
REQ-024 READ: rd_req SHALL be accepted every cycle until last step is accepted; accepted request yields rd_valid=1 with rd_data=mem[rd_ptr], rd_step=rd_ptr exactly one cycle later (latency 1).
REQ-025 rd_ptr SHALL decrement per accepted request if reverse, else increment; back-to-back requests give one vector per cycle.
REQ-026 Accepting the last step SHALL return state to IDLE; read_done SHALL pulse coincident with the final rd_valid.
REQ-027 rd_req in IDLE or WRITE SHALL be ignored (no rd_valid); wr_valid outside WRITE SHALL be ignored, no memory change.
REQ-028 rd_data and rd_step SHALL hold last value when rd_valid = 0.
REQ-029 start may be accepted in the cycle of the final rd_valid (state already IDLE); new frame SHALL not corrupt the in-flight output.
REQ-030 Memory SHALL be DEPTH x NUM_STATES*DATA_W; contents retained across frames; data stored and returned bit-exact, no arithmetic.

Reset
REQ-031 rst asserted SHALL immediately force IDLE, wr_ptr=rd_ptr=0, wr_ready=0, rd_valid=0, rd_data=0, rd_step=0, write_done=read_done=err=busy=0.
REQ-032 Memory contents SHALL NOT be reset; rst mid-frame abandons the frame, no done pulse.

Verification
REQ-033 Forward frame: start, frame_len=4, reverse=0; write vectors with state k = 16*step+k; 4 rd_req -> rd_step 0,1,2,3, data bit-exact, read_done with step 3.
REQ-034 Reverse frame: frame_len=DEPTH=64, reverse=1, metric -1 (0xFFFF) in step 63 state 7 -> first rd_valid rd_step=63 carries 0xFFFF in MSBs, last rd_step=0 with read_done.
REQ-035 Illegal length: start with frame_len=0, then 65 -> err pulse each, busy stays 0, wr_ready stays 0.
REQ-036 Backpressure/gaps: wr_valid toggled 1,0,1,1 and rd_req gapped -> only handshaked vectors stored, rd_valid exactly 1 cycle after each accepted rd_req.
REQ-037 Reset mid-WRITE after 2 of 4 vectors -> all outputs 0 asynchronously, IDLE; new 2-step frame then reads correctly.
REQ-038 Ignored traffic: rd_req during WRITE and start during READ -> no rd_valid, no frame restart, frame completes normally.
